// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
// Holds the sequencer state encoding, requester port ids and the word
// geometry used for alignment and range checks.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int         WORD_BYTES = 4;
    // Low byte-address bits that must be zero for a word-aligned access.
    localparam logic [1:0] ALIGN_MASK = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle for one memory requester.
//   req_valid/req_addr/req_we/req_wdata : request, driven by the requester
//   req_ready                           : request accepted this cycle
//   rsp_valid/rsp_rdata/rsp_err         : one-cycle response pulse + data
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. The requester holds req_valid and the request
// fields stable until that edge; req_ready is never high while req_valid is
// low. rsp_valid is a single-cycle pulse with no back-pressure; rsp_rdata
// and rsp_err stay stable until the next response on the same port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_port_arbiter_rr.sv
// Two-input round-robin arbiter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_if/req_dm: fetch / data requester valid
//   can_accept   : the sequencer is able to take a request this cycle
//   grant        : port id chosen this cycle (PORT_IF or PORT_DM)
//   accept       : a request is taken this cycle (also updates last_grant)
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_if,
    input  logic req_dm,
    input  logic can_accept,
    output logic grant,
    output logic accept
);

    logic last_grant;

    // On a conflict the port that did not win last time gets the grant; a
    // lone requester always wins.
    always_comb begin
        grant = PORT_IF;
        if (req_if && req_dm) begin
            grant = ~last_grant;
        end else if (req_dm) begin
            grant = PORT_DM;
        end
        accept = (req_if || req_dm) && can_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_IF;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified byte-addressed memory between instruction fetch
// (read-only) and data access (read/write). Each accepted request runs
// through a one-cycle registered memory phase (ACCESS) followed by a
// one-cycle response (RESP); misaligned or out-of-range requests skip the
// memory phase and respond with an error one cycle after acceptance.
//   clk, rst_n        : clock, asynchronous active-low reset
//   if_port (slave)   : fetch requester bundle (req_we/req_wdata ignored)
//   dm_port (slave)   : data requester bundle
//   mem_adr/mem_wd    : memory address / write data, held outside ACCESS
//   mem_we            : memory write enable, high only in ACCESS of a store
//   mem_rd            : memory read data, combinational from mem_adr
//   dbg_state         : current sequencer state
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave if_port,
    mem_port_arbiter_if.slave dm_port,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - WORD_BYTES);

    state_t            state, next_state;
    logic              can_accept, grant, accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we, acc_we, acc_legal;
    logic              lat_port, lat_we;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              if_err_q, dm_err_q;

    assign can_accept = (state == IDLE) || (state == RESP);

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (if_port.req_valid),
        .req_dm     (dm_port.req_valid),
        .can_accept (can_accept),
        .grant      (grant),
        .accept     (accept)
    );

    // Request fields of the granted port; fetches can never write.
    always_comb begin
        sel_addr  = (grant == PORT_DM) ? dm_port.req_addr  : if_port.req_addr;
        sel_wdata = (grant == PORT_DM) ? dm_port.req_wdata : if_port.req_wdata;
        sel_we    = (grant == PORT_DM) ? dm_port.req_we    : if_port.req_we;
        acc_we    = (grant == PORT_DM) && sel_we;
        acc_legal = ((sel_addr[1:0] & ALIGN_MASK) == 2'b00) && (sel_addr <= LAST_WORD);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = acc_legal ? ACCESS : RESP;
            ACCESS:  next_state = RESP;
            RESP:    next_state = accept ? (acc_legal ? ACCESS : RESP) : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // mem_adr/mem_wd load only on a legal accept, so they present the access
    // throughout ACCESS and keep their value across error responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_port   <= PORT_IF;
            lat_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wd     <= '0;
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            dm_rdata_q <= '0;
            dm_err_q   <= 1'b0;
        end else if (accept) begin
            lat_port <= grant;
            lat_we   <= acc_we;
            if (acc_legal) begin
                mem_adr <= sel_addr;
                mem_wd  <= sel_wdata;
            end else if (grant == PORT_DM) begin
                dm_rdata_q <= '0;
                dm_err_q   <= 1'b1;
            end else begin
                if_rdata_q <= '0;
                if_err_q   <= 1'b1;
            end
        end else if (state == ACCESS) begin
            if (lat_port == PORT_DM) begin
                dm_rdata_q <= lat_we ? '0 : mem_rd;
                dm_err_q   <= 1'b0;
            end else begin
                if_rdata_q <= mem_rd;
                if_err_q   <= 1'b0;
            end
        end
    end

    // Decoded from state so an asynchronous reset drops the write at once.
    assign mem_we    = (state == ACCESS) && lat_we;
    assign dbg_state = state;

    assign if_port.req_ready = accept && (grant == PORT_IF);
    assign dm_port.req_ready = accept && (grant == PORT_DM);
    assign if_port.rsp_valid = (state == RESP) && (lat_port == PORT_IF);
    assign dm_port.rsp_valid = (state == RESP) && (lat_port == PORT_DM);
    assign if_port.rsp_rdata = if_rdata_q;
    assign if_port.rsp_err   = if_err_q;
    assign dm_port.rsp_rdata = dm_rdata_q;
    assign dm_port.rsp_err   = dm_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word-array memory model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 2048;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;
    state_t            dbg_state;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_bus ();
    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dm_bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_port   (if_bus.slave),
        .dm_port   (dm_bus.slave),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:MEM_BYTES/4-1];
    logic        mem_init_done = 1'b0;
    int          we_cnt = 0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < MEM_BYTES / 4; i++) mem[i] <= 32'h0;
            mem[32'h010 >> 2] <= 32'hDEADBEEF;
            mem[32'h040 >> 2] <= 32'h11111111;
            mem[32'h7FC >> 2] <= 32'hCAFEF00D;
            mem_init_done     <= 1'b1;
        end else if (mem_we) begin
            mem[mem_adr[10:2]] <= mem_wd;
        end
    end

    assign mem_rd = (mem_adr < ADDR_W'(MEM_BYTES)) ? mem[mem_adr[10:2]] : 32'h0;

    always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic        exp_port_q[$];
    int          exp_cyc_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        if_bus.req_valid = 1'b0; if_bus.req_addr = '0; if_bus.req_we = 1'b0; if_bus.req_wdata = '0;
        dm_bus.req_valid = 1'b0; dm_bus.req_addr = '0; dm_bus.req_we = 1'b0; dm_bus.req_wdata = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- single request driver ----------------
    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        exp_access;
        int          exp_we_cycles;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic do_req(input vec_t v);
        logic got;
        int   waited;
        int   we_before;
        we_before = we_cnt;
        if (v.port == PORT_DM) begin
            dm_bus.req_valid = 1'b1; dm_bus.req_addr = v.addr;
            dm_bus.req_we = v.we;    dm_bus.req_wdata = v.wdata;
        end else begin
            if_bus.req_valid = 1'b1; if_bus.req_addr = v.addr;
            if_bus.req_we = v.we;    if_bus.req_wdata = v.wdata;
        end
        got = 1'b0;
        waited = 0;
        while (!got && waited < 20) begin
            @(negedge clk);
            got = (v.port == PORT_DM) ? dm_bus.req_ready : if_bus.req_ready;
            if (!got) begin
                @(posedge clk); #1;
                waited++;
            end
        end
        check("req_accept", {31'b0, got}, 32'd1);
        if (!got) begin
            idle_inputs();
            return;
        end
        check("req_ready_other", {31'b0, (v.port == PORT_DM) ? if_bus.req_ready : dm_bus.req_ready}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        if (v.exp_access) begin
            @(negedge clk);
            check("access_state", 32'(dbg_state), 32'(ACCESS));
            check("access_mem_adr", mem_adr, v.addr);
            check("access_mem_wd", mem_wd, v.wdata);
            check("access_mem_we", {31'b0, mem_we}, {31'b0, v.exp_we_cycles == 1});
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("rsp_valid", {31'b0, (v.port == PORT_DM) ? dm_bus.rsp_valid : if_bus.rsp_valid}, 32'd1);
        check("rsp_valid_other", {31'b0, (v.port == PORT_DM) ? if_bus.rsp_valid : dm_bus.rsp_valid}, 32'd0);
        check("rsp_rdata", (v.port == PORT_DM) ? dm_bus.rsp_rdata : if_bus.rsp_rdata, v.exp_rdata);
        check("rsp_err", {31'b0, (v.port == PORT_DM) ? dm_bus.rsp_err : if_bus.rsp_err}, {31'b0, v.exp_err});
        check("rsp_mem_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        check("we_cycles", 32'(we_cnt - we_before), 32'(v.exp_we_cycles));
    endtask

    // ---------------- held-valid stream driver ----------------
    // Requesters stay valid until n_acc accepts have been seen; accepts are
    // expected every other cycle and each response two cycles after accept.
    task automatic stream(input logic use_if, input logic use_dm, input int n_acc,
                          input logic [31:0] if_exp, input logic [31:0] dm_exp);
        int   acc_cnt;
        int   both_cnt;
        logic port;
        logic exp_port;
        logic [31:0] e;
        acc_cnt  = 0;
        both_cnt = 0;
        exp_q.delete(); exp_port_q.delete(); exp_cyc_q.delete();
        if_bus.req_valid = use_if; if_bus.req_addr = 32'h010;
        dm_bus.req_valid = use_dm; dm_bus.req_addr = 32'h7FC; dm_bus.req_we = 1'b0;
        for (int c = 0; c < 2 * n_acc + 4; c++) begin
            @(negedge clk);
            if (if_bus.req_ready && dm_bus.req_ready) both_cnt++;
            if (if_bus.rsp_valid || dm_bus.rsp_valid) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    exp_port = exp_port_q.pop_front();
                    check("stream_rsp_cycle", 32'(c), 32'(exp_cyc_q.pop_front()));
                    check("stream_rsp_port", {31'b0, dm_bus.rsp_valid}, {31'b0, exp_port});
                    check("stream_rsp_rdata", dm_bus.rsp_valid ? dm_bus.rsp_rdata : if_bus.rsp_rdata, e);
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra_rsp: got response at cycle %0d expected none", c);
                end
            end
            if (if_bus.req_ready || dm_bus.req_ready) begin
                port = dm_bus.req_ready ? PORT_DM : PORT_IF;
                if (use_if && use_dm) exp_port = (acc_cnt % 2 == 0) ? PORT_DM : PORT_IF;
                else                  exp_port = use_dm ? PORT_DM : PORT_IF;
                check("stream_grant", {31'b0, port}, {31'b0, exp_port});
                check("stream_accept_cycle", 32'(c), 32'(2 * acc_cnt));
                exp_q.push_back(port ? dm_exp : if_exp);
                exp_port_q.push_back(port);
                exp_cyc_q.push_back(c + 2);
                acc_cnt++;
            end
            @(posedge clk); #1;
            if (acc_cnt >= n_acc) idle_inputs();
        end
        check("stream_accepts", 32'(acc_cnt), 32'(n_acc));
        check("stream_both_ready", 32'(both_cnt), 32'd0);
        check("stream_pending_rsp", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[$];
    int   rst_rsp_seen;

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_mem_adr", mem_adr, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_if_rsp", {29'b0, if_bus.rsp_valid, if_bus.rsp_err, if_bus.req_ready}, 32'd0);
        check("rst_dm_rsp", {29'b0, dm_bus.rsp_valid, dm_bus.rsp_err, dm_bus.req_ready}, 32'd0);
        check("rst_if_rdata", if_bus.rsp_rdata, 32'h0);
        check("rst_dm_rdata", dm_bus.rsp_rdata, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // port, addr, we, wdata, access, we_cycles, rdata, err
        vecs.push_back('{PORT_IF, 32'h010, 1'b0, 32'h0,        1'b1, 0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{PORT_DM, 32'h020, 1'b1, 32'h12345678, 1'b1, 1, 32'h0,        1'b0});
        vecs.push_back('{PORT_DM, 32'h020, 1'b0, 32'h0,        1'b1, 0, 32'h12345678, 1'b0});
        vecs.push_back('{PORT_DM, 32'h022, 1'b1, 32'h0BADF00D, 1'b0, 0, 32'h0,        1'b1});
        vecs.push_back('{PORT_DM, 32'h020, 1'b0, 32'h0,        1'b1, 0, 32'h12345678, 1'b0});
        vecs.push_back('{PORT_DM, 32'h7FC, 1'b0, 32'h0,        1'b1, 0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{PORT_DM, 32'h800, 1'b0, 32'h0,        1'b0, 0, 32'h0,        1'b1});
        vecs.push_back('{PORT_IF, 32'h7FC, 1'b1, 32'h55555555, 1'b1, 0, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{PORT_IF, 32'h013, 1'b0, 32'h0,        1'b0, 0, 32'h0,        1'b1});
        vecs.push_back('{PORT_DM, 32'h100, 1'b1, 32'h0F0F0F0F, 1'b1, 1, 32'h0,        1'b0});
        vecs.push_back('{PORT_IF, 32'h100, 1'b0, 32'h0,        1'b1, 0, 32'h0F0F0F0F, 1'b0});
        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

        // Both requesters held from reset: DM wins the first conflict.
        apply_reset();
        stream(1'b1, 1'b1, 4, 32'hDEADBEEF, 32'hCAFEF00D);

        // Back-to-back fetches held valid.
        stream(1'b1, 1'b0, 4, 32'hDEADBEEF, 32'h0);

        // Reset asserted in the ACCESS cycle of a store to 0x040.
        dm_bus.req_valid = 1'b1; dm_bus.req_addr = 32'h040;
        dm_bus.req_we = 1'b1;    dm_bus.req_wdata = 32'hAAAA5555;
        @(negedge clk);
        check("rst_store_ready", {31'b0, dm_bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        #2;
        check("rst_store_we_high", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_store_we_drop", {31'b0, mem_we}, 32'd0);
        check("rst_store_state", 32'(dbg_state), 32'(IDLE));
        rst_rsp_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (dm_bus.rsp_valid || if_bus.rsp_valid) rst_rsp_seen++;
        end
        check("rst_store_no_rsp", 32'(rst_rsp_seen), 32'd0);
        check("rst_store_mem", mem[32'h040 >> 2], 32'h11111111);
        @(posedge clk); #1 rst_n = 1'b1;
        do_req('{PORT_IF, 32'h010, 1'b0, 32'h0, 1'b1, 0, 32'hDEADBEEF, 1'b0});
        check("post_rst_mem", mem[32'h040 >> 2], 32'h11111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified byte-addressed instruction/data memory of the multicycle core between two requesters: instruction fetch (IF, read-only) and data access (DM, read/write).
- Arbitrates requests and sequences each access through a registered address/write phase.
- Returns read data or a write acknowledgement with fixed latency.
- Rejects misaligned or out-of-range accesses without touching memory.

Parameters:
- ADDR_W, 32, request/memory address width in bits.
- DATA_W, 32, word width; memory word is 4 bytes, big-endian.
- MEM_BYTES, 2048, memory size in bytes; last legal word address is MEM_BYTES-4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req_valid  input  1  fetch request present.
- if_req_addr  input  ADDR_W  fetch byte address.
- if_req_ready  output  1  fetch request accepted this cycle.
- if_rsp_valid  output  1  one-cycle pulse: fetch response.
- if_rsp_rdata  output  DATA_W  fetched word.
- if_rsp_err  output  1  fetch was misaligned or out of range.
- dm_req_valid  input  1  data request present.
- dm_req_addr  input  ADDR_W  data byte address.
- dm_req_we  input  1  1 = store, 0 = load.
- dm_req_wdata  input  DATA_W  store data.
- dm_req_ready  output  1  data request accepted this cycle.
- dm_rsp_valid  output  1  one-cycle pulse: data response.
- dm_rsp_rdata  output  DATA_W  load word (0 for stores).
- dm_rsp_err  output  1  data access misaligned or out of range.
- mem_adr  output  ADDR_W  memory byte address.
- mem_wd  output  DATA_W  memory write data.
- mem_we  output  1  memory write enable.
- mem_rd  input  DATA_W  memory read data (combinational from mem_adr).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=IF.
  - mem_adr=0, mem_wd=0, mem_we=0.
  - All rsp_valid/err=0, all rsp_rdata=0.
  - In-flight access is dropped; a pending write is never committed (mem_we falls immediately).
- FSM states: IDLE, ACCESS, RESP.
- Acceptance:
  - Requests are accepted only in IDLE or RESP.
  - req_ready is combinational and goes to at most one port: the granted port, when it has valid.
  - Handshake is valid&ready; valid must be held until ready; ready is never asserted for a port with valid=0.
- Arbitration:
  - Single valid: that port is granted.
  - Both valid: grant the port other than last_grant (round-robin). last_grant updates on every accept.
  - Because last_grant resets to IF, the first conflict after reset goes to DM.
- On accept, latch port id, addr, we (IF forces we=0), and wdata.
  - Legal access (addr[1:0]==0 and addr<=MEM_BYTES-4): next state ACCESS.
  - Otherwise: next state RESP with err=1, and no memory cycle occurs.
- ACCESS (exactly 1 cycle):
  - mem_adr=latched addr, mem_wd=latched wdata, mem_we=latched we.
  - Capture mem_rd into the response register for a load, or 0 for a store.
  - Next state RESP.
- RESP (1 cycle):
  - The latched port's rsp_valid=1 with rdata/err; the other port's rsp_valid=0.
  - mem_we=0.
  - A new accept may occur in the same cycle; otherwise next state IDLE.
- Timing:
  - Latency: accept at edge N, memory access during cycle N+1, rsp_valid during cycle N+2.
  - Peak throughput: one access per 2 cycles. Error path: rsp in cycle N+1.
- Output holding:
  - mem_adr/mem_wd hold their last value outside ACCESS.
  - mem_we is high only in ACCESS of a legal store.
  - rsp_rdata/err hold until the next response.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - port id constants PORT_IF=0, PORT_DM=1.
  - WORD_BYTES=4 and an alignment-mask constant.
- One natural sub-module: rr_arbiter2 (2-input round-robin grant, last_grant register, update-on-accept input).

Test Plan:
- IF read at 0x010 with memory word 0xDEADBEEF -> if_req_ready same cycle; mem_adr=0x010, mem_we=0 at cycle+1; if_rsp_valid=1, rdata=0xDEADBEEF at cycle+2.
- DM store 0x12345678 to 0x020, then DM load 0x020 -> mem_we=1 for exactly one cycle; load returns 0x12345678; store response has rdata=0, err=0.
- IF and DM valid together from reset, both held for 4 accesses -> grant order DM, IF, DM, IF; ready never high on both ports in one cycle.
- DM store to 0x022 (misaligned), then DM load at 0x7FC vs 0x800 with MEM_BYTES=2048 -> 0x022: err=1 at cycle+1, mem_we never asserted. 0x7FC: err=0. 0x800: err=1.
- Back-to-back IF requests held valid -> accepts every 2 cycles, rsp_valid pulses every 2 cycles, no gaps beyond that.
- rst_n driven low during ACCESS of a store to 0x040 -> mem_we drops immediately, memory word at 0x040 unchanged, no rsp_valid; after release, first request is served normally.
